div_unit: RTL and testbench

//   Multi-cycle radix-2 restoring divider serving the EX stage's DIV/DIVU requests. EX raises

---
 rtl/div_unit.sv | 156 +++++++++++++++
 tb/tb_div_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Radix-2 restoring divider answering EX's DIV/DIVU request with {remainder, quotient}; optional DIV_EARLY_OUT_EN skips the loop when |dividend| < |divisor|.
// Latency: ready at T+WIDTH+2 after acceptance edge T; divide-by-zero (and early-out when enabled) at T+2.
// Backpressure: start is a held level; result/ready stay in END while start is high, annul aborts from any state.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 annul,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BYZERO,
        S_ON,
        S_FIX,
        S_END
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [WIDTH-1:0]   rem, rem_nxt;
    logic [WIDTH-1:0]   quo, quo_nxt;
    logic [WIDTH-1:0]   dvs, dvs_nxt;
    logic               neg_q, neg_q_nxt;
    logic               neg_r, neg_r_nxt;
    logic [2*WIDTH-1:0] result_nxt;
    logic               ready_nxt;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;

    assign abs_a = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    assign abs_b = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

    // Partial remainder stays below the divisor, so the WIDTH+1-bit difference never
    // overflows and its top bit is the sign of the trial subtraction.
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs};

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rem_nxt    = rem;
        quo_nxt    = quo;
        dvs_nxt    = dvs;
        neg_q_nxt  = neg_q;
        neg_r_nxt  = neg_r;
        result_nxt = '0;
        ready_nxt  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && !annul) begin
                    neg_q_nxt = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                    neg_r_nxt = signed_div & opdata1[WIDTH-1];
                    cnt_nxt   = '0;
                    rem_nxt   = '0;
                    quo_nxt   = abs_a;
                    dvs_nxt   = abs_b;
                    if (opdata2 == '0) begin
                        state_nxt = S_BYZERO;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (abs_a < abs_b) begin
                        quo_nxt   = '0;
                        rem_nxt   = opdata1;
                        state_nxt = S_FIX;
                    end
`endif
                    else begin
                        state_nxt = S_ON;
                    end
                end
            end
            S_BYZERO: begin
                rem_nxt   = '0;
                quo_nxt   = '0;
                state_nxt = S_END;
            end
            S_ON: begin
                if (cnt != CW'(WIDTH)) begin
                    if (!trial[WIDTH]) begin
                        rem_nxt = trial[WIDTH-1:0];
                        quo_nxt = {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_nxt = shifted[WIDTH-1:0];
                        quo_nxt = {quo[WIDTH-2:0], 1'b0};
                    end
                    cnt_nxt = cnt + CW'(1);
                end else begin
                    // Most-negative / -1 leaves quo at 2^(WIDTH-1) with no negation: wraps as intended.
                    if (neg_q) quo_nxt = -quo;
                    if (neg_r) rem_nxt = -rem;
                    cnt_nxt   = '0;
                    state_nxt = S_END;
                end
            end
            S_FIX: begin
                state_nxt = S_END;
            end
            S_END: begin
                if (start) begin
                    ready_nxt  = 1'b1;
                    result_nxt = {rem, quo};
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (annul) begin
            state_nxt  = S_IDLE;
            cnt_nxt    = '0;
            ready_nxt  = 1'b0;
            result_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            ready  <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rem    <= rem_nxt;
            quo    <= quo_nxt;
            dvs    <= dvs_nxt;
            neg_q  <= neg_q_nxt;
            neg_r  <= neg_r_nxt;
            ready  <= ready_nxt;
            result <= result_nxt;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: constant vectors, hand-written abort/reset sequences, random ops vs arithmetic model.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset, start, annul, signed_div;
    logic [31:0] opdata1, opdata2;
    logic [63:0] result;
    logic        ready;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .annul      (annul),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .result     (result),
        .ready      (ready)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          sgn;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
        string       name;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer division (truncating), zero divisor yields zero.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                    output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa, sb, lq, lr, ma, mb;
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        if (b == 32'd0) begin
            q   = '0;
            r   = '0;
            lat = 2;
        end else begin
            lq  = sa / sb;
            lr  = sa % sb;
            q   = lq[31:0];
            r   = lr[31:0];
            ma  = (sa < 0) ? -sa : sa;
            mb  = (sb < 0) ? -sb : sb;
            lat = (EARLY && (ma < mb)) ? 2 : 34;
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                          input logic [31:0] q, input logic [31:0] r, input int lat, input string name);
        logic [63:0] exp;
        int          n;
        bit          seen;
        bit          junk;
        exp        = {r, q};
        seen       = 1'b0;
        junk       = 1'b0;
        n          = 0;
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        start      = 1'b1;
        annul      = 1'b0;
        reset      = 1'b0;
        while (!seen && n < 60) begin
            step();
            n++;
            if (n == 1) begin
                opdata1 = $urandom;
                opdata2 = $urandom;
            end
            if (ready) seen = 1'b1;
            else if (result != 64'd0) junk = 1'b1;
        end
        check({name, " latency"}, seen ? n - 1 : 999, lat);
        check({name, " result"}, result, exp);
        check({name, " zero before ready"}, {63'd0, junk}, 64'd0);
        step();
        step();
        check({name, " held ready"}, {63'd0, ready}, 64'd1);
        check({name, " held result"}, result, exp);
        start = 1'b0;
        step();
        check({name, " drop ready"}, {63'd0, ready}, 64'd0);
        check({name, " drop result"}, result, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        bit   seen;
        logic [31:0] a, b, q, r;
        bit   sgn;
        int   lat;

        vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          34, "divu 100/7"};
        vecs[1]  = '{32'hFFFFFFF9,   32'h2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   34, "div -7/2"};
        vecs[2]  = '{32'h7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'h1,          34, "div 7/-2"};
        vecs[3]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'h0,          34, "div min/-1"};
        vecs[4]  = '{32'd5,          32'd0,          1'b0, 32'd0,          32'd0,          2,  "divu 5/0"};
        vecs[5]  = '{32'd3,          32'd10,         1'b0, 32'd0,          32'd3,          EARLY ? 2 : 34, "divu 3/10"};
        vecs[6]  = '{32'd9,          32'd4,          1'b0, 32'd2,          32'd1,          34, "divu 9/4"};
        vecs[7]  = '{32'hFFFFFFFB,   32'd0,          1'b1, 32'd0,          32'd0,          2,  "div -5/0"};
        vecs[8]  = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          34, "divu max/1"};
        vecs[9]  = '{32'hFFFFFFFD,   32'd10,         1'b1, 32'd0,          32'hFFFFFFFD,   EARLY ? 2 : 34, "div -3/10"};
        vecs[10] = '{32'h80000000,   32'hFFFFFFFF,   1'b0, 32'd0,          32'h80000000,   EARLY ? 2 : 34, "divu 2^31/max"};

        reset      = 1'b1;
        start      = 1'b1;
        annul      = 1'b0;
        signed_div = 1'b0;
        opdata1    = 32'd5;
        opdata2    = 32'd0;
        step();
        step();
        step();
        check("reset ready", {63'd0, ready}, 64'd0);
        check("reset result", result, 64'd0);
        start = 1'b0;
        reset = 1'b0;
        step();

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].q, vecs[i].r, vecs[i].lat, vecs[i].name);

        // Annul mid-operation: ready must never rise, next op runs full length.
        opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        for (int i = 0; i < 10; i++) step();
        annul = 1'b1;
        start = 1'b0;
        step();
        annul = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ready) seen = 1'b1;
        end
        check("annul no ready", {63'd0, seen}, 64'd0);
        run_op(32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 34, "after annul 9/4");

        // Annul in IDLE wins over start: acceptance only once annul drops.
        opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1; annul = 1'b1;
        for (int i = 0; i < 5; i++) step();
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34, "idle annul 100/7");

        // Reset mid-operation with start held: aborts, then restarts from scratch.
        opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        for (int i = 0; i < 15; i++) step();
        reset = 1'b1;
        step();
        check("midop reset ready", {63'd0, ready}, 64'd0);
        check("midop reset result", result, 64'd0);
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34, "after reset 100/7");

        // Start dropped while running: operation completes silently, END lasts one cycle.
        opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; start = 1'b1;
        for (int i = 0; i < 5; i++) step();
        start = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 45; i++) begin
            step();
            if (ready) seen = 1'b1;
        end
        check("start drop no ready", {63'd0, seen}, 64'd0);
        run_op(32'hFFFFFFF9, 32'h2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 34, "after drop -7/2");

        for (int i = 0; i < 25; i++) begin
            sgn = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = $urandom; b = $urandom_range(1, 15); end
                2: begin a = $urandom_range(0, 20); b = $urandom; end
                3: begin a = 32'h80000000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : $urandom; end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            ref_div(a, b, sgn, q, r, lat);
            run_op(a, b, sgn, q, r, lat, $sformatf("rand%0d %h/%h s%0d", i, a, b, sgn));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
